ones_counter_seq: RTL and testbench

Parametrised, multi-cycle population counter. It accepts a WIDTH-bit word over a valid/ready handshake and counts its set bits, or its clear bits in zero-count mode. Counting covers CHUNK bits per cycle and accumulates internally. The result is presented on a valid/ready output port. The block is the sequential, streamable successor to the team's 8-bit combinational ones counter and sits between a data producer and any consumer of bit-weight statistics.

---
 rtl/ones_counter_pkg.sv | 17 +
 rtl/ones_counter_seq_chunk_popcount.sv | 20 ++
 rtl/ones_counter_seq.sv | 97 +++++++++
 tb/tb_ones_counter_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ones_counter_pkg.sv
// Shared types and elaboration helpers for the sequential ones counter.
package ones_counter_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Ceiling log2; callers pass n+1 to size a counter that must reach n.
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit chunk_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/ones_counter_seq_chunk_popcount.sv
// Combinational popcount of one CHUNK-bit slice; the 8-bit counter generalised.
module chunk_popcount
  import ones_counter_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]             bits,
  output logic [clog2(CHUNK + 1)-1:0]  count
);

  localparam int PC_W = clog2(CHUNK + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + PC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/ones_counter_seq.sv
// Multi-cycle population counter: accepts a word, counts CHUNK bits per cycle
// from the LSB end of a right-shifting hold register, then presents the total.
module ones_counter_seq
  import ones_counter_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CNT_W  = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
);

  localparam int PC_W  = clog2(CHUNK + 1);
  localparam int IDX_W = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_param_check
    $error("ones_counter_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] hold;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] acc;
  logic [PC_W-1:0]  chunk_count;
  logic             last_chunk;

  chunk_popcount #(.CHUNK(CHUNK)) u_popcount (
    .bits  (hold[CHUNK-1:0]),
    .count (chunk_count)
  );

  assign last_chunk = (idx == IDX_W'(NCHUNK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Handshake outputs decode the state register only, never the peer's valid/ready.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_count  = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_count = acc;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Zero-count mode is folded in at acceptance by inverting the word once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      idx  <= '0;
      acc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hold <= in_mode ? ~in_data : in_data;
            idx  <= '0;
            acc  <= '0;
          end
        end
        BUSY: begin
          hold <= hold >> CHUNK;
          idx  <= idx + 1'b1;
          acc  <= acc + CNT_W'(chunk_count);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_counter_seq.sv
// Scoreboard bench for ones_counter_seq at 32/8, 8/8 and 16/4.
module tb_ones_counter_seq;

  localparam int MAXW = 40;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [31:0] in_data;
  logic [5:0]  out_count;

  logic        s8_in_valid, s8_in_ready, s8_in_mode, s8_out_valid, s8_out_ready;
  logic [7:0]  s8_in_data;
  logic [3:0]  s8_out_count;

  logic        s16_in_valid, s16_in_ready, s16_in_mode, s16_out_valid, s16_out_ready;
  logic [15:0] s16_in_data;
  logic [4:0]  s16_out_count;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  ones_counter_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );

  ones_counter_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s8_in_valid), .in_ready(s8_in_ready), .in_data(s8_in_data), .in_mode(s8_in_mode),
    .out_valid(s8_out_valid), .out_ready(s8_out_ready), .out_count(s8_out_count)
  );

  ones_counter_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s16_in_valid), .in_ready(s16_in_ready), .in_data(s16_in_data), .in_mode(s16_in_mode),
    .out_valid(s16_out_valid), .out_ready(s16_out_ready), .out_count(s16_out_count)
  );

  // Offer one word to the 32-bit DUT (assumed idle) for exactly one edge.
  task automatic drive_main(input logic [31:0] d, input logic m);
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    exp_q.push_back(m ? 32 - $countones(d) : $countones(d));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_main(output int lat);
    lat = 0;
    while (!out_valid && lat < MAXW) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat, exp;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_count !== 6'd0) begin errors++; $display("[TB] FAIL reset_out_count: got %0d expected 0", out_count); end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_main(32'hFFFF_FFFF, 1'b0);
    wait_main(lat);
    exp = exp_q.pop_front();
    checks++; if (out_count !== 6'(exp)) begin errors++; $display("[TB] FAIL reset_pre_count: got %0d expected %0d", out_count, exp); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_count !== 6'd0) begin errors++; $display("[TB] FAIL async_out_count: got %0d expected 0", out_count); end
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ones();
    logic [31:0] words [5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1111_1111, 32'hEEEE_EEEE};
    int lat, exp;
    foreach (words[i]) begin
      drive_main(words[i], 1'b0);
      wait_main(lat);
      checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL ones_latency[%0d]: got %0d expected 4", i, lat); end
      exp = exp_q.pop_front();
      checks++; if (out_count !== 6'(exp)) begin errors++; $display("[TB] FAIL ones_count[%0d]: got %0d expected %0d", i, out_count, exp); end
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ones_rearm[%0d]: got %b expected 1", i, in_ready); end
    end
  endtask

  task automatic test_zeros();
    logic [31:0] words [3] = '{32'h0F0F_0F0F, 32'h0000_0000, 32'hFFFF_FFFF};
    int lat, exp;
    foreach (words[i]) begin
      drive_main(words[i], 1'b1);
      wait_main(lat);
      exp = exp_q.pop_front();
      checks++; if (out_count !== 6'(exp)) begin errors++; $display("[TB] FAIL zeros_count[%0d]: got %0d expected %0d", i, out_count, exp); end
      @(posedge clk); #1;
    end
    // Mode and data wiggle while busy; only the accepted word may matter.
    drive_main(32'h0F0F_0F0F, 1'b1);
    lat = 0;
    while (!out_valid && lat < MAXW) begin
      in_mode = ~in_mode;
      in_data = ~in_data;
      @(posedge clk); #1;
      lat++;
    end
    exp = exp_q.pop_front();
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL toggle_latency: got %0d expected 4", lat); end
    checks++; if (out_count !== 6'(exp)) begin errors++; $display("[TB] FAIL toggle_count: got %0d expected %0d", out_count, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat, exp;
    out_ready = 1'b0;
    drive_main(32'h0000_00F0, 1'b0);
    wait_main(lat);
    exp = exp_q.pop_front();
    in_data  = 32'h0000_0003;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_count !== 6'(exp)) begin errors++; $display("[TB] FAIL bp_count[%0d]: got %0d expected %0d", c, out_count, exp); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", c, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    exp_q.push_back($countones(in_data));
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_consumed: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_back: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_accepted: got %b expected 0", in_ready); end
    wait_main(lat);
    exp = exp_q.pop_front();
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 4", lat); end
    checks++; if (out_count !== 6'(exp)) begin errors++; $display("[TB] FAIL bp_second_count: got %0d expected %0d", out_count, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, exp;
    drive_main(32'hFFFF_FFFF, 1'b0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_count !== 6'd0) begin errors++; $display("[TB] FAIL mid_out_count: got %0d expected 0", out_count); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_result: got %b expected 0", out_valid); end
    drive_main(32'h0000_00FF, 1'b0);
    wait_main(lat);
    exp = exp_q.pop_front();
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL mid_latency: got %0d expected 4", lat); end
    checks++; if (out_count !== 6'(exp)) begin errors++; $display("[TB] FAIL mid_resubmit: got %0d expected %0d", out_count, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    logic [7:0] vals [5] = '{8'h00, 8'h11, 8'h33, 8'h77, 8'hFF};
    int lat, exp;
    foreach (vals[i]) begin
      s8_in_data  = vals[i];
      s8_in_mode  = 1'b0;
      s8_in_valid = 1'b1;
      exp_q.push_back($countones(vals[i]));
      @(posedge clk); #1;
      s8_in_valid = 1'b0;
      lat = 0;
      while (!s8_out_valid && lat < MAXW) begin
        @(posedge clk); #1;
        lat++;
      end
      exp = exp_q.pop_front();
      checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL w8_latency[%0d]: got %0d expected 1", i, lat); end
      checks++; if (s8_out_count !== 4'(exp)) begin errors++; $display("[TB] FAIL w8_count[%0d]: got %0d expected %0d", i, s8_out_count, exp); end
      @(posedge clk); #1;
    end
    for (int m = 0; m < 2; m++) begin
      s16_in_data  = 16'hA5A5;
      s16_in_mode  = m[0];
      s16_in_valid = 1'b1;
      exp_q.push_back(m == 1 ? 16 - $countones(s16_in_data) : $countones(s16_in_data));
      @(posedge clk); #1;
      s16_in_valid = 1'b0;
      lat = 0;
      while (!s16_out_valid && lat < MAXW) begin
        @(posedge clk); #1;
        lat++;
      end
      exp = exp_q.pop_front();
      checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL w16_latency[%0d]: got %0d expected 4", m, lat); end
      checks++; if (s16_out_count !== 5'(exp)) begin errors++; $display("[TB] FAIL w16_count[%0d]: got %0d expected %0d", m, s16_out_count, exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
    s8_in_valid = 1'b0; s8_in_data = '0; s8_in_mode = 1'b0; s8_out_ready = 1'b1;
    s16_in_valid = 1'b0; s16_in_data = '0; s16_in_mode = 1'b0; s16_out_ready = 1'b1;
    test_reset();
    test_ones();
    test_zeros();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
